// File: rtl/uart_tx_sched_if.sv
// Requester/line bundle for the shared UART transmit scheduler.
// Handshake: a requester raises reqN with dataN stable. The block samples requests only
// while idle. It answers with a one-cycle ackN, and the byte is captured at that same edge.
// The requester must drop reqN or change dataN in the cycle after ackN, because a held
// request is granted again once the line is free. dbg_state encoding is
// 0=IDLE, 1=WAIT_TICK, 2=START, 3=DATA, 4=STOP.
interface uart_tx_sched_if #(parameter int DATA_BITS = 8);
  logic                 baud_tick;
  logic                 req0;
  logic [DATA_BITS-1:0] data0;
  logic                 ack0;
  logic                 req1;
  logic [DATA_BITS-1:0] data1;
  logic                 ack1;
  logic                 txd;
  logic                 busy;
  logic                 grant_id;
  logic [2:0]           dbg_state;
  logic [2:0]           dbg_bitcnt;

  modport master (
    output baud_tick, req0, data0, req1, data1,
    input  ack0, ack1, txd, busy, grant_id, dbg_state, dbg_bitcnt
  );

  modport slave (
    input  baud_tick, req0, data0, req1, data1,
    output ack0, ack1, txd, busy, grant_id, dbg_state, dbg_bitcnt
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin UART transmitter: grants the line, then shifts the byte out
// as start / DATA_BITS data (LSB first) / STOP_BITS stop, one bit per baud_tick.
module uart_tx_sched #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_l,
  uart_tx_sched_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_t;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t               state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [2:0]           bitcnt, bitcnt_n;
  logic                 stopcnt, stopcnt_n;
  logic                 txd_q, txd_n;
  logic                 busy_q, busy_n;
  logic                 ack0_q, ack0_n;
  logic                 ack1_q, ack1_n;
  logic                 grant_q, grant_n;
  logic                 last_q, last_n;
  logic                 pick;

  // On a tie the requester not served last wins; otherwise whoever is asking.
  assign pick = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bitcnt_n  = bitcnt;
    stopcnt_n = stopcnt;
    txd_n     = txd_q;
    busy_n    = busy_q;
    ack0_n    = 1'b0;
    ack1_n    = 1'b0;
    grant_n   = grant_q;
    last_n    = last_q;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          shreg_n = pick ? bus.data1 : bus.data0;
          ack0_n  = ~pick;
          ack1_n  = pick;
          grant_n = pick;
          last_n  = pick;
          busy_n  = 1'b1;
          state_n = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (bus.baud_tick) begin
          txd_n   = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bus.baud_tick) begin
          txd_n    = shreg[0];
          bitcnt_n = 3'd0;
          state_n  = DATA;
        end
      end
      DATA: begin
        // The register shifts right so the next data bit is always at index 1.
        if (bus.baud_tick) begin
          if (bitcnt == LAST_BIT) begin
            txd_n     = 1'b1;
            stopcnt_n = 1'b0;
            state_n   = STOP;
          end else begin
            txd_n    = shreg[1];
            shreg_n  = shreg >> 1;
            bitcnt_n = bitcnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (bus.baud_tick) begin
          if (stopcnt == LAST_STOP) begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            stopcnt_n = stopcnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= 3'd0;
      stopcnt <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bitcnt  <= bitcnt_n;
      stopcnt <= stopcnt_n;
      txd_q   <= txd_n;
      busy_q  <= busy_n;
      ack0_q  <= ack0_n;
      ack1_q  <= ack1_n;
      grant_q <= grant_n;
      last_q  <= last_n;
    end
  end

  assign bus.txd        = txd_q;
  assign bus.busy       = busy_q;
  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.grant_id   = grant_q;
  assign bus.dbg_state  = state;
  assign bus.dbg_bitcnt = bitcnt;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: an 8N1 instance and a 7-bit / 2-stop instance,
// with expected line levels queued at grant time and popped at each baud tick.
module tb_uart_tx_sched;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd3;

  logic sys_clk = 1'b0;
  logic sys_rst_l;

  uart_tx_sched_if #(.DATA_BITS(8)) bus_a ();
  uart_tx_sched_if #(.DATA_BITS(7)) bus_b ();

  uart_tx_sched #(.DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .bus       (bus_a.slave)
  );

  uart_tx_sched #(.DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .bus       (bus_b.slave)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  int         tests = 0;
  int         failed = 0;
  logic [1:0] exp_q[$];   // {busy, txd} expected after each baud tick
  bit         tick_en;
  int         tick_period;
  int         tick_cnt;
  logic       last_tick;
  logic       model_last_a;
  logic       model_last_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: records the tick seen by this edge, then drives the next tick value.
  task automatic step();
    last_tick = bus_a.baud_tick;
    @(posedge sys_clk);
    #1;
    check("ack_overlap", 32'(bus_a.ack0 & bus_a.ack1), 32'd0);
    if (tick_en) tick_cnt = (tick_cnt == tick_period - 1) ? 0 : tick_cnt + 1;
    bus_a.baud_tick = tick_en && (tick_cnt == tick_period - 1);
    bus_b.baud_tick = bus_a.baud_tick;
  endtask

  task automatic tick_phase(input int period, input int cnt);
    tick_en     = 1'b1;
    tick_period = period;
    tick_cnt    = cnt;
    bus_a.baud_tick = (cnt == period - 1);
    bus_b.baud_tick = bus_a.baud_tick;
  endtask

  task automatic tick_stop();
    tick_en = 1'b0;
    bus_a.baud_tick = 1'b0;
    bus_b.baud_tick = 1'b0;
  endtask

  function automatic logic [1:0] obs_line(input int sel);
    if (sel == 1) return {bus_b.busy, bus_b.txd};
    return {bus_a.busy, bus_a.txd};
  endfunction

  function automatic logic [3:0] obs_grant(input int sel);
    if (sel == 1) return {bus_b.ack0, bus_b.ack1, bus_b.grant_id, bus_b.busy};
    return {bus_a.ack0, bus_a.ack1, bus_a.grant_id, bus_a.busy};
  endfunction

  // Expected levels: start, data LSB first, first stop, remaining stop ticks (busy drops last).
  task automatic push_frame(input logic [7:0] data, input int nb, input int ns);
    logic [7:0] d;
    d = data;
    exp_q.push_back(2'b10);
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back({1'b1, d[0]});
      d = d >> 1;
    end
    exp_q.push_back(2'b11);
    for (int i = 0; i < ns - 1; i++) exp_q.push_back(2'b11);
    exp_q.push_back(2'b01);
  endtask

  // driver: presents requests, checks the ack pulse against the arbiter model, queues the frame
  task automatic grant(input int sel, input logic r0, input logic r1,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input int nb, input int ns, input bit keep, input string tag);
    logic win;
    logic last;
    if (sel == 1) begin
      bus_b.req0 = r0; bus_b.req1 = r1; bus_b.data0 = d0[6:0]; bus_b.data1 = d1[6:0];
      last = model_last_b;
    end else begin
      bus_a.req0 = r0; bus_a.req1 = r1; bus_a.data0 = d0; bus_a.data1 = d1;
      last = model_last_a;
    end
    step();
    win = (r0 && r1) ? ~last : r1;
    if (sel == 1) model_last_b = win; else model_last_a = win;
    check({tag, ".grant"}, 32'(obs_grant(sel)), 32'({~win, win, win, 1'b1}));
    push_frame(win ? d1 : d0, nb, ns);
    if (!keep) begin
      if (sel == 1) begin bus_b.req0 = 1'b0; bus_b.req1 = 1'b0; end
      else begin bus_a.req0 = 1'b0; bus_a.req1 = 1'b0; end
    end
    step();
    check({tag, ".ack_pulse"}, 32'(obs_grant(sel) >> 2), 32'd0);
  endtask

  // scoreboard: per tick pop one level; the line must not move between ticks
  task automatic check_bits(input int sel, input int n, input string tag);
    logic [1:0] prev;
    logic [1:0] exp;
    bit         held;
    int         waited;
    for (int k = 0; k < n; k++) begin
      prev   = obs_line(sel);
      held   = 1'b1;
      waited = 0;
      do begin
        step();
        waited++;
        if (!last_tick && obs_line(sel) !== prev) held = 1'b0;
      end while (!last_tick && waited < 64);
      if (exp_q.size() == 0) exp = 2'bxx;
      else exp = exp_q.pop_front();
      check($sformatf("%s.bit%0d", tag, k), 32'({held, last_tick, obs_line(sel)}),
            32'({1'b1, 1'b1, exp}));
    end
  endtask

  initial begin
    logic [8:0] snap;
    bit         stable;

    bus_a.req0 = 1'b0; bus_a.req1 = 1'b0; bus_a.data0 = '0; bus_a.data1 = '0;
    bus_b.req0 = 1'b0; bus_b.req1 = 1'b0; bus_b.data0 = '0; bus_b.data1 = '0;
    tick_stop();
    tick_period  = 16;
    tick_cnt     = 0;
    model_last_a = 1'b1;
    model_last_b = 1'b1;
    sys_rst_l    = 1'b0;

    // reset state
    repeat (3) step();
    check("reset_a", 32'({bus_a.txd, bus_a.busy, bus_a.grant_id, bus_a.ack0, bus_a.ack1, bus_a.dbg_state}),
          32'({5'b10000, ST_IDLE}));
    check("reset_b", 32'({bus_b.txd, bus_b.busy, bus_b.grant_id, bus_b.ack0, bus_b.ack1, bus_b.dbg_state}),
          32'({5'b10000, ST_IDLE}));
    sys_rst_l = 1'b1;
    step();

    // single request, 0xA5
    tick_phase(16, 0);
    grant(0, 1'b1, 1'b0, 8'hA5, 8'h00, 8, 1, 1'b0, "single");
    check_bits(0, 11, "single");

    // reset during data bit 3 of a requester-1 frame
    tick_phase(16, 0);
    grant(0, 1'b0, 1'b1, 8'h00, 8'h3C, 8, 1, 1'b0, "rst_pre");
    check_bits(0, 5, "rst_pre");
    repeat (3) step();
    sys_rst_l = 1'b0;
    step();
    sys_rst_l = 1'b1;
    check("rst_mid", 32'({bus_a.txd, bus_a.busy, bus_a.grant_id, bus_a.ack0, bus_a.ack1, bus_a.dbg_state}),
          32'({5'b10000, ST_IDLE}));
    exp_q.delete();
    model_last_a = 1'b1;
    model_last_b = 1'b1;
    repeat (40) begin
      step();
      check("rst_idle", 32'({bus_a.busy, bus_a.ack0, bus_a.ack1, bus_a.txd}), 32'(4'b0001));
    end

    // simultaneous held requests: r0, r1, r0 back to back
    tick_phase(16, 0);
    grant(0, 1'b1, 1'b1, 8'h11, 8'h22, 8, 1, 1'b1, "tie0");
    check_bits(0, 11, "tie0");
    grant(0, 1'b1, 1'b1, 8'h11, 8'h22, 8, 1, 1'b1, "tie1");
    check_bits(0, 11, "tie1");
    grant(0, 1'b1, 1'b1, 8'h11, 8'h22, 8, 1, 1'b0, "tie2");
    check_bits(0, 11, "tie2");

    // tick coincident with the granting edge is ignored
    tick_phase(16, 15);
    grant(0, 1'b1, 1'b0, 8'hC3, 8'h00, 8, 1, 1'b0, "tick_grant");
    check("tick_grant.wait", 32'({bus_a.dbg_state, bus_a.txd}), 32'({ST_WAIT, 1'b1}));
    check_bits(0, 11, "tick_grant");

    // tick-free stall in DATA
    tick_phase(16, 0);
    grant(0, 1'b0, 1'b1, 8'h00, 8'h5A, 8, 1, 1'b0, "stall");
    check_bits(0, 4, "stall_pre");
    check("stall.pos", 32'({bus_a.dbg_state, bus_a.dbg_bitcnt}), 32'({ST_DATA, 3'd2}));
    snap = {bus_a.txd, bus_a.busy, bus_a.dbg_bitcnt, bus_a.dbg_state};
    tick_stop();
    stable = 1'b1;
    repeat (1000) begin
      step();
      if ({bus_a.txd, bus_a.busy, bus_a.dbg_bitcnt, bus_a.dbg_state} !== snap) stable = 1'b0;
    end
    check("stall.hold", 32'(stable), 32'd1);
    tick_phase(16, 0);
    check_bits(0, 7, "stall_post");

    // 7 data bits, 2 stop bits, 0x7F
    tick_phase(16, 0);
    grant(1, 1'b1, 1'b0, 8'h7F, 8'h00, 7, 2, 1'b0, "param");
    check_bits(1, 11, "param");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
